// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants and the reorder buffer entry layout.
package tomasulo_pkg;

  localparam int unsigned TAG_W     = 6;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PTR_W     = 4;

  localparam logic [TAG_W-1:0] INVALID_TAG = 6'd16;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    value;
  } rob_entry_t;

  // Tags 0..15 name entries; anything with upper bits set is invalid.
  function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
    return tag[TAG_W-1:PTR_W] == '0;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping 4-bit ring pointer with synchronous clear and increment.
module rob_ptr
  import tomasulo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate, CDB completion, in-order commit.
module reorder_buffer
  import tomasulo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_dest,
  output logic                 alloc_ready,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_value,
  input  logic [TAG_W-1:0]     query_tag1,
  output logic                 query_ready1,
  output logic [DATA_W-1:0]    query_value1,
  input  logic [TAG_W-1:0]     query_tag2,
  output logic                 query_ready2,
  output logic [DATA_W-1:0]    query_value2,
  output logic                 commit_valid,
  output logic [REG_IDX_W-1:0] commit_reg,
  output logic [DATA_W-1:0]    commit_value,
  output logic [TAG_W-1:0]     commit_tag
);

  rob_entry_t       entries_q [ROB_DEPTH];
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cdb_idx;
  logic             alloc_fire;
  logic             commit_fire;
  logic             cdb_fire;

  assign cdb_idx     = cdb_tag[PTR_W-1:0];
  assign alloc_ready = count_q < (PTR_W + 1)'(ROB_DEPTH);
  assign alloc_tag   = alloc_ready ? TAG_W'(tail) : INVALID_TAG;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign commit_fire = entries_q[head].busy && entries_q[head].ready && !flush;
  assign cdb_fire    = cdb_valid && tag_valid(cdb_tag) && entries_q[cdb_idx].busy && !flush;

  rob_ptr u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .inc   (commit_fire),
    .ptr   (head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .inc   (alloc_fire),
    .ptr   (tail)
  );

  // Commit is applied last so it wins over a same-edge CDB write to the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i].busy  <= 1'b0;
        entries_q[i].ready <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        entries_q[tail].busy  <= 1'b1;
        entries_q[tail].ready <= 1'b0;
        entries_q[tail].dest  <= alloc_dest;
      end
      if (cdb_fire) begin
        entries_q[cdb_idx].ready <= 1'b1;
        entries_q[cdb_idx].value <= cdb_value;
      end
      if (commit_fire) begin
        entries_q[head].busy  <= 1'b0;
        entries_q[head].ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      unique case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_value <= '0;
      commit_tag   <= INVALID_TAG;
    end else if (commit_fire) begin
      commit_valid <= 1'b1;
      commit_reg   <= entries_q[head].dest;
      commit_value <= entries_q[head].value;
      commit_tag   <= TAG_W'(head);
    end else begin
      commit_valid <= 1'b0;
      commit_tag   <= INVALID_TAG;
    end
  end

  always_comb begin
    query_ready1 = tag_valid(query_tag1) && entries_q[query_tag1[PTR_W-1:0]].busy &&
                   entries_q[query_tag1[PTR_W-1:0]].ready;
    query_value1 = query_ready1 ? entries_q[query_tag1[PTR_W-1:0]].value : '0;
    query_ready2 = tag_valid(query_tag2) && entries_q[query_tag2[PTR_W-1:0]].busy &&
                   entries_q[query_tag2[PTR_W-1:0]].ready;
    query_value2 = query_ready2 ? entries_q[query_tag2[PTR_W-1:0]].value : '0;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_dest = '0;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic [5:0]  query_tag1 = '0;
  logic        query_ready1;
  logic [31:0] query_value1;
  logic [5:0]  query_tag2 = '0;
  logic        query_ready2;
  logic [31:0] query_value2;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [31:0] commit_value;
  logic [5:0]  commit_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .query_tag1   (query_tag1),
    .query_ready1 (query_ready1),
    .query_value1 (query_value1),
    .query_tag2   (query_tag2),
    .query_ready2 (query_ready2),
    .query_value2 (query_value2),
    .commit_valid (commit_valid),
    .commit_reg   (commit_reg),
    .commit_value (commit_value),
    .commit_tag   (commit_tag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; alloc_valid = 0; cdb_valid = 0;
    rst_n = 0;
    #3;
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    tests++; if (commit_tag !== 6'd16) begin fails++; $display("FAIL rst_async_tag: got %0d want 16", commit_tag); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL rst_async_ready: got %b want 1", alloc_ready); end
    #20 rst_n = 1;
    repeat (3) step();
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
    tests++; if (alloc_tag !== 6'd0) begin fails++; $display("FAIL reset_alloc_tag: got %0d want 0", alloc_tag); end
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL reset_commit_valid: got %b want 0", commit_valid); end
    tests++; if (commit_tag !== 6'd16) begin fails++; $display("FAIL reset_commit_tag: got %0d want 16", commit_tag); end
    tests++; if (commit_reg !== 5'd0 || commit_value !== 32'd0) begin fails++; $display("FAIL reset_commit_data: got r%0d %h want r0 0", commit_reg, commit_value); end
  endtask

  task automatic test_in_order();
    alloc_valid = 1; alloc_dest = 5'd3;
    tests++; if (alloc_tag !== 6'd0) begin fails++; $display("FAIL order_tag0: got %0d want 0", alloc_tag); end
    step();
    tests++; if (alloc_tag !== 6'd1) begin fails++; $display("FAIL order_tag1: got %0d want 1", alloc_tag); end
    alloc_dest = 5'd5;
    step();
    alloc_valid = 0;
    query_tag1 = 6'd1; query_tag2 = 6'd0;
    cdb_valid = 1; cdb_tag = 6'd1; cdb_value = 32'hBEEF;
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL order_no_early_commit: got %b want 0", commit_valid); end
    tests++; if (query_ready1 !== 1'b1 || query_value1 !== 32'hBEEF) begin fails++; $display("FAIL order_query1: got %b %h want 1 0000beef", query_ready1, query_value1); end
    tests++; if (query_ready2 !== 1'b0 || query_value2 !== 32'd0) begin fails++; $display("FAIL order_query2: got %b %h want 0 0", query_ready2, query_value2); end
    cdb_tag = 6'd0; cdb_value = 32'h1234;
    step();
    cdb_valid = 0;
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL order_no_bypass: got %b want 0", commit_valid); end
    step();
    tests++; if (commit_valid !== 1'b1 || commit_reg !== 5'd3 || commit_value !== 32'h1234 || commit_tag !== 6'd0)
      begin fails++; $display("FAIL order_commit0: got v%b r%0d %h t%0d want v1 r3 00001234 t0", commit_valid, commit_reg, commit_value, commit_tag); end
    step();
    tests++; if (commit_valid !== 1'b1 || commit_reg !== 5'd5 || commit_value !== 32'hBEEF || commit_tag !== 6'd1)
      begin fails++; $display("FAIL order_commit1: got v%b r%0d %h t%0d want v1 r5 0000beef t1", commit_valid, commit_reg, commit_value, commit_tag); end
    step();
    tests++; if (commit_valid !== 1'b0 || commit_tag !== 6'd16 || commit_reg !== 5'd5 || commit_value !== 32'hBEEF)
      begin fails++; $display("FAIL order_idle_hold: got v%b r%0d %h t%0d want v0 r5 0000beef t16", commit_valid, commit_reg, commit_value, commit_tag); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_valid = 1;
    for (int i = 0; i < 16; i++) begin
      alloc_dest = 5'(i);
      tests++; if (alloc_tag !== 6'(i)) begin fails++; $display("FAIL full_tag%0d: got %0d want %0d", i, alloc_tag, i); end
      step();
    end
    alloc_valid = 0;
    tests++; if (alloc_ready !== 1'b0 || alloc_tag !== 6'd16) begin fails++; $display("FAIL full_flags: got %b %0d want 0 16", alloc_ready, alloc_tag); end
    cdb_valid = 1; cdb_tag = 6'd0; cdb_value = 32'hA0;
    step();
    cdb_valid = 0;
    step();
    tests++; if (commit_valid !== 1'b1 || commit_reg !== 5'd0 || commit_value !== 32'hA0 || commit_tag !== 6'd0)
      begin fails++; $display("FAIL full_commit_r0: got v%b r%0d %h t%0d want v1 r0 000000a0 t0", commit_valid, commit_reg, commit_value, commit_tag); end
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0) begin fails++; $display("FAIL full_wrap: got %b %0d want 1 0", alloc_ready, alloc_tag); end
    alloc_valid = 1; alloc_dest = 5'd7;
    step();
    alloc_valid = 0;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL refill_ready: got %b want 0", alloc_ready); end
    cdb_valid = 1; cdb_tag = 6'd1; cdb_value = 32'hB1;
    step();
    cdb_valid = 0;
    alloc_valid = 1; alloc_dest = 5'd9;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL no_full_bypass: got %b want 0", alloc_ready); end
    step();
    alloc_valid = 0;
    tests++; if (commit_valid !== 1'b1 || commit_reg !== 5'd1 || commit_value !== 32'hB1 || commit_tag !== 6'd1)
      begin fails++; $display("FAIL full_commit_alloc: got v%b r%0d %h t%0d want v1 r1 000000b1 t1", commit_valid, commit_reg, commit_value, commit_tag); end
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd1) begin fails++; $display("FAIL alloc_refused: got %b %0d want 1 1", alloc_ready, alloc_tag); end
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL full_no_extra_commit: got %b want 0", commit_valid); end
  endtask

  task automatic test_ignored_cdb();
    do_reset();
    alloc_valid = 1; alloc_dest = 5'd4;
    step();
    alloc_dest = 5'd6;
    step();
    alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 6'd16; cdb_value = 32'hDEAD;
    step();
    cdb_tag = 6'd5; cdb_value = 32'hCAFE;
    step();
    cdb_valid = 0;
    query_tag1 = 6'd16; query_tag2 = 6'd5;
    #1;
    tests++; if (query_ready1 !== 1'b0 || query_value1 !== 32'd0) begin fails++; $display("FAIL ign_query16: got %b %h want 0 0", query_ready1, query_value1); end
    tests++; if (query_ready2 !== 1'b0 || query_value2 !== 32'd0) begin fails++; $display("FAIL ign_query_free: got %b %h want 0 0", query_ready2, query_value2); end
    query_tag1 = 6'd0;
    #1;
    tests++; if (query_ready1 !== 1'b0) begin fails++; $display("FAIL ign_tag16_alias: got %b want 0", query_ready1); end
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL ign_commit: got %b want 0", commit_valid); end
    cdb_valid = 1; cdb_tag = 6'd1; cdb_value = 32'h11;
    step();
    cdb_value = 32'h22;
    step();
    cdb_valid = 0;
    query_tag1 = 6'd1;
    #1;
    tests++; if (query_ready1 !== 1'b1 || query_value1 !== 32'h22) begin fails++; $display("FAIL overwrite: got %b %h want 1 00000022", query_ready1, query_value1); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_valid = 1;
    for (int i = 0; i < 5; i++) begin
      alloc_dest = 5'(10 + i);
      step();
    end
    alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 6'd1; cdb_value = 32'h55;
    step();
    cdb_tag = 6'd2; cdb_value = 32'h66;
    step();
    cdb_valid = 0;
    query_tag1 = 6'd1; query_tag2 = 6'd2;
    #1;
    tests++; if (query_ready1 !== 1'b1 || query_ready2 !== 1'b1) begin fails++; $display("FAIL pre_flush_ready: got %b %b want 1 1", query_ready1, query_ready2); end
    flush = 1; alloc_valid = 1; alloc_dest = 5'd20;
    cdb_valid = 1; cdb_tag = 6'd3; cdb_value = 32'h77;
    step();
    flush = 0; alloc_valid = 0; cdb_valid = 0;
    tests++; if (commit_valid !== 1'b0 || commit_tag !== 6'd16) begin fails++; $display("FAIL flush_commit: got v%b t%0d want v0 t16", commit_valid, commit_tag); end
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0) begin fails++; $display("FAIL flush_ptrs: got %b %0d want 1 0", alloc_ready, alloc_tag); end
    tests++; if (query_ready1 !== 1'b0 || query_ready2 !== 1'b0) begin fails++; $display("FAIL flush_entries: got %b %b want 0 0", query_ready1, query_ready2); end
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL flush_late_commit: got %b want 0", commit_valid); end
    flush = 1;
    step();
    flush = 0;
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0 || commit_valid !== 1'b0)
      begin fails++; $display("FAIL flush_empty: got %b %0d v%b want 1 0 v0", alloc_ready, alloc_tag, commit_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_valid = 1; alloc_dest = 5'd8;
    step();
    alloc_dest = 5'd9;
    step();
    alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 6'd0; cdb_value = 32'h99;
    step();
    cdb_valid = 0;
    step();
    tests++; if (commit_valid !== 1'b1 || commit_reg !== 5'd8) begin fails++; $display("FAIL pre_reset_commit: got v%b r%0d want v1 r8", commit_valid, commit_reg); end
    #3 rst_n = 0;
    #1;
    tests++; if (commit_valid !== 1'b0 || commit_tag !== 6'd16 || commit_reg !== 5'd0 || commit_value !== 32'd0)
      begin fails++; $display("FAIL async_reset_commit: got v%b r%0d %h t%0d want v0 r0 0 t16", commit_valid, commit_reg, commit_value, commit_tag); end
    tests++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0) begin fails++; $display("FAIL async_reset_alloc: got %b %0d want 1 0", alloc_ready, alloc_tag); end
    #2 rst_n = 1;
    step();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got %b want 0", commit_valid); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_ignored_cdb();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
